// File: rtl/go_sync_multi.sv
// N-channel toggle-to-pulse synchroniser: each foreign-domain flip line is
// synchronised, edge-detected and queued as a per-channel valid/ready request.
module go_sync_multi #(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEPTH       = 3,
   parameter int EDGE_MODE   = 0,
   localparam int CW         = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [N-1:0]    flip_async,
   output logic [N-1:0]    go_valid,
   input  logic [N-1:0]    go_ready,
   input  logic [N-1:0]    ovf_clr,
   output logic [N-1:0]    ovf,
   output logic [N*CW-1:0] pend_cnt,
   output logic            armed
);
   localparam int AW = $clog2(SYNC_STAGES + 2);
   localparam logic [AW-1:0] ARM_DONE = AW'(SYNC_STAGES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

   logic [SYNC_STAGES-1:0] sync_r [N];
   logic [N-1:0]           prev_r;
   logic [CW-1:0]          cnt_r [N];
   logic [CW-1:0]          cnt_nxt_s [N];
   logic [N-1:0]           ovf_r;
   logic [N-1:0]           ovf_nxt_s;
   logic [N-1:0]           event_s;
   logic [N-1:0]           ev_q_s;
   logic [N-1:0]           xfer_s;
   logic [N-1:0]           drop_s;
   logic [AW-1:0]          arm_cnt_r;
   logic                   armed_s;

   // Arm counter: masks the first SYNC_STAGES+1 edges so a line already high at release is not an event
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         arm_cnt_r <= {AW{1'b0}};
      end else if (arm_cnt_r != ARM_DONE) begin
         arm_cnt_r <= arm_cnt_r + AW'(1);
      end else begin
         arm_cnt_r <= arm_cnt_r;
      end
   end

   assign armed_s = (arm_cnt_r == ARM_DONE);

   // Synchroniser chains and delayed copy of the last stage
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int c = 0; c < N; c++) begin
            sync_r[c] <= {SYNC_STAGES{1'b0}};
         end
         prev_r <= {N{1'b0}};
      end else begin
         for (int c = 0; c < N; c++) begin
            sync_r[c] <= {sync_r[c][SYNC_STAGES-2:0], flip_async[c]};
            prev_r[c] <= sync_r[c][SYNC_STAGES-1];
         end
      end
   end

   // Event detection on registered synchronised values
   always_comb begin
      event_s = {N{1'b0}};
      for (int c = 0; c < N; c++) begin
         case (EDGE_MODE)
            32'd1:   event_s[c] = sync_r[c][SYNC_STAGES-1] & ~prev_r[c];
            32'd2:   event_s[c] = ~sync_r[c][SYNC_STAGES-1] & prev_r[c];
            default: event_s[c] = sync_r[c][SYNC_STAGES-1] ^ prev_r[c];
         endcase
      end
   end

   // Pending-count and sticky-overflow next state; simultaneous event and transfer cancel
   always_comb begin
      ev_q_s    = {N{1'b0}};
      xfer_s    = {N{1'b0}};
      drop_s    = {N{1'b0}};
      ovf_nxt_s = ovf_r;
      for (int c = 0; c < N; c++) begin
         cnt_nxt_s[c] = cnt_r[c];
         ev_q_s[c]    = event_s[c] & armed_s;
         xfer_s[c]    = go_ready[c] & (cnt_r[c] != {CW{1'b0}});
         case ({ev_q_s[c], xfer_s[c]})
            2'b10: begin
               if (cnt_r[c] < CNT_MAX) begin
                  cnt_nxt_s[c] = cnt_r[c] + CW'(1);
               end else begin
                  drop_s[c] = 1'b1;
               end
            end
            2'b01:   cnt_nxt_s[c] = cnt_r[c] - CW'(1);
            default: cnt_nxt_s[c] = cnt_r[c];
         endcase
         if (drop_s[c]) begin
            ovf_nxt_s[c] = 1'b1;
         end else if (ovf_clr[c]) begin
            ovf_nxt_s[c] = 1'b0;
         end else begin
            ovf_nxt_s[c] = ovf_r[c];
         end
      end
   end

   // Pending-count and overflow state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int c = 0; c < N; c++) begin
            cnt_r[c] <= {CW{1'b0}};
         end
         ovf_r <= {N{1'b0}};
      end else begin
         for (int c = 0; c < N; c++) begin
            cnt_r[c] <= cnt_nxt_s[c];
         end
         ovf_r <= ovf_nxt_s;
      end
   end

   // Output decode from registered state only
   always_comb begin
      go_valid = {N{1'b0}};
      pend_cnt = {(N*CW){1'b0}};
      for (int c = 0; c < N; c++) begin
         go_valid[c]            = (cnt_r[c] != {CW{1'b0}});
         pend_cnt[c*CW +: CW]   = cnt_r[c];
      end
   end

   assign ovf   = ovf_r;
   assign armed = armed_s;

endmodule

// File: doc/go_sync_multi.md
Name: go_sync_multi

Overview:
- N-channel toggle-to-pulse event synchroniser. It is the receive half of the flip-based "go" crossing, generalised.
- Each channel takes a toggle (flip) line driven from a foreign clock domain and synchronises it through SYNC_STAGES flops.
- Each detected event is converted into a queued request with a valid/ready handshake, so back-to-back go events are not lost while the consumer is busy.
- Sits at the clock-domain boundary of CNN engine control, in front of layer/tile schedulers.

Parameters:
- N, 4, number of independent channels.
- SYNC_STAGES, 2, synchroniser depth; legal range 2..4.
- DEPTH, 3, maximum pending events per channel; legal range 1..15.
- EDGE_MODE, 0, event definition: 0 = any change of synchronised line (toggle), 1 = rising edge only, 2 = falling edge only.
- CW, $clog2(DEPTH+1), pending counter width (derived, not overridable).

Ports:
- clk  in  1  destination clock.
- rstn  in  1  asynchronous active-low reset.
- flip_async  in  N  per-channel toggle lines from the foreign domain; asynchronous to clk.
- go_valid  out  N  per-channel event pending.
- go_ready  in  N  per-channel consumer accept.
- ovf_clr  in  N  per-channel sticky-overflow clear pulse.
- ovf  out  N  per-channel sticky overflow flag.
- pend_cnt  out  N*CW  per-channel pending count; channel c occupies bits [c*CW +: CW].
- armed  out  1  high once the post-reset masking window has ended.

Behaviour:
- Reset (rstn low, asynchronous): all sync flops, prev, cnt, ovf, arm counter = 0. Outputs: go_valid=0, ovf=0, pend_cnt=0, armed=0.
- Sync chain, per channel: sync[0] <= flip_async[c], then sync[i] <= sync[i-1]; prev <= sync[S-1] every cycle.
- Event, combinational on registered values:
  - EDGE_MODE 0: sync[S-1] != prev.
  - EDGE_MODE 1: sync[S-1] & ~prev.
  - EDGE_MODE 2: ~sync[S-1] & prev.
- Arming:
  - After rstn deasserts, the arm counter increments each edge until it reaches SYNC_STAGES+1, then holds; armed = (counter == SYNC_STAGES+1).
  - While armed=0, events are discarded: no count, no ovf. This prevents a spurious event when flip_async is already 1 at reset release.
- Latency: a flip_async change set up before edge E1 reaches sync[S-1] at edge E_S. cnt increments at E_{S+1}, and go_valid is high in the cycle after E_{S+1}. Total SYNC_STAGES+1 edges.
- go_valid[c] = (cnt[c] != 0), decoded from the registered count; no combinational path from go_ready.
- Transfer = go_valid & go_ready at a clock edge. go_ready while go_valid=0 has no effect.
- cnt update per edge:
  - event only, cnt<DEPTH: +1.
  - event only, cnt==DEPTH: unchanged, event dropped, ovf set.
  - transfer only: -1.
  - event and transfer together: unchanged, including at cnt==DEPTH; no overflow.
  - neither: unchanged.
- ovf: sticky. Set by a dropped event, cleared by ovf_clr. If set and clear occur on the same edge, set wins.
- Channels are fully independent; no cross-channel priority.
- Reset mid-operation: pending events and ovf are lost, and the arming window restarts.
- Input constraint: the source must hold each flip level at least SYNC_STAGES+1 destination cycles (toggle mode). Faster toggling may merge or miss events; this is not detected.

Test Plan:
- Reset release with flip_async=4'b1010 held -> armed rises after 3 edges (S=2); go_valid stays 0, pend_cnt stays 0.
- Ch0 single toggle 0->1 with go_ready=1 -> go_valid[0] high exactly 3 edges after the input change, for 1 cycle; pend_cnt[0] sequence 0,1,0.
- Ch1 four toggles spaced 4 cycles apart, go_ready=0, DEPTH=3 -> pend_cnt[1] goes to 3, ovf[1]=1 after the 4th event. Then go_ready=1 for 3 cycles -> counts 2,1,0, go_valid[1] falls; ovf[1] stays 1 until ovf_clr[1].
- Ch2 at cnt=3 with event and go_ready on the same edge -> cnt stays 3, ovf[2] stays 0. Ovf set and ovf_clr on the same edge -> ovf=1.
- EDGE_MODE=1 build, toggle 0->1->0 -> exactly one event, pend_cnt=1.
- EDGE_MODE=2 build, same stimulus -> exactly one event on the falling transition.
- Assert rstn low with pend_cnt=2 and ovf=1 -> all outputs 0 immediately (asynchronous). After release, armed is re-qualified and the next toggle is counted normally.
